// File: rtl/y86_regfile_sb_pkg.sv
// rtl/y86_regfile_sb_pkg.sv - shared register IDs, types and icode enum for the Y86 register file slice
//
// Purpose : common constants for the register file and the upstream decoder.
// Contents: REG_RSP / REG_NONE register IDs, reg_id_t, icode_e (decoded upstream).
package y86_regfile_sb_pkg;

   localparam int REG_RSP  = 4;
   localparam int REG_NONE = 15;

   typedef logic [3:0] reg_id_t;

   typedef enum logic [3:0] {
      I_HALT   = 4'h0,
      I_NOP    = 4'h1,
      I_RRMOVQ = 4'h2,
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_JXX    = 4'h7,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_e;

endpackage

// File: rtl/y86_regfile_sb_if.sv
// rtl/y86_regfile_sb_if.sv - read, write-back and issue bus of the Y86 register file
//
// Purpose : groups the register file's read ports, two write-back ports and the
//           issue/scoreboard handshake.
// Modports: master - pipeline side (drives addresses, write-backs, issue)
//           slave  - register file side (returns read data, iss_rdy, stall, sb_err)
interface y86_regfile_sb_if #(
   parameter int DATA_W = 64,
   parameter int RW     = 4
);
   logic [RW-1:0]     srcA;
   logic [RW-1:0]     srcB;
   logic [DATA_W-1:0] valA;
   logic [DATA_W-1:0] valB;
   logic              wenE;
   logic [RW-1:0]     dstE;
   logic [DATA_W-1:0] valE;
   logic              wenM;
   logic [RW-1:0]     dstM;
   logic [DATA_W-1:0] valM;
   logic              iss_en;
   logic [RW-1:0]     iss_dstE;
   logic [RW-1:0]     iss_dstM;
   logic              iss_rdy;
   logic              stall;
   logic              sb_err;

   modport master (
      output srcA, srcB, wenE, dstE, valE, wenM, dstM, valM,
             iss_en, iss_dstE, iss_dstM,
      input  valA, valB, iss_rdy, stall, sb_err
   );

   modport slave (
      input  srcA, srcB, wenE, dstE, valE, wenM, dstM, valM,
             iss_en, iss_dstE, iss_dstM,
      output valA, valB, iss_rdy, stall, sb_err
   );
endinterface

// File: rtl/y86_regfile_sb_scoreboard.sv
// rtl/y86_regfile_sb_scoreboard.sv - per-register pending-write counters, issue ready, stall and error flag
//
// Purpose : tracks outstanding write-backs per register; raises stall for pending
//           sources, back-pressures issue on counter saturation, flags underflow.
// Ports   : clk, rst_n (async active-low)
//           src_a/src_b          in   read addresses checked for hazards
//           wen_e/dst_e, wen_m/dst_m in write-backs (decrement)
//           iss_en/iss_dst_e/iss_dst_m in issue (increment)
//           iss_rdy/stall/sb_err out
// Config  : REGFILE_BYPASS_EN - stall ignores a source whose last pending write
//           completes this cycle.
module y86_regfile_sb_scoreboard #(
   parameter int NREGS  = 16,
   parameter int PEND_W = 2,
   parameter int RW     = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [RW-1:0] src_a,
   input  logic [RW-1:0] src_b,
   input  logic          wen_e,
   input  logic [RW-1:0] dst_e,
   input  logic          wen_m,
   input  logic [RW-1:0] dst_m,
   input  logic          iss_en,
   input  logic [RW-1:0] iss_dst_e,
   input  logic [RW-1:0] iss_dst_m,
   output logic          iss_rdy,
   output logic          stall,
   output logic          sb_err
);

   localparam logic [RW-1:0]     RNONE   = RW'(NREGS - 1);
   localparam logic [PEND_W-1:0] CNT_MAX = '1;
   localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

   logic [PEND_W-1:0] cnt_q [NREGS];
   logic [PEND_W-1:0] cnt_d [NREGS];
   logic              sb_err_q;
   logic              sb_err_d;

   logic [NREGS-1:0]  dec;
   logic [NREGS-1:0]  inc_req;
   logic [NREGS-1:0]  full;
   logic              iss_fire;
   logic              stall_a;
   logic              stall_b;

   always_comb begin
      dec      = '0;
      inc_req  = '0;
      full     = '0;
      sb_err_d = sb_err_q;
      for (int r = 0; r < NREGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (RW'(r) != RNONE) begin
            // dst_e == dst_m collapses to one decrement; same for issue.
            dec[r]     = (wen_e && dst_e == RW'(r)) || (wen_m && dst_m == RW'(r));
            inc_req[r] = (iss_dst_e == RW'(r)) || (iss_dst_m == RW'(r));
            full[r]    = (cnt_q[r] == CNT_MAX);
         end
      end

      // A saturated counter can still take an issue if it drains this cycle.
      iss_rdy  = ~|(inc_req & full & ~dec);
      iss_fire = iss_en && iss_rdy;

      for (int r = 0; r < NREGS; r++) begin
         if (iss_fire && inc_req[r] && !dec[r]) begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         end else if (dec[r] && !(iss_fire && inc_req[r])) begin
            if (cnt_q[r] == '0) begin
               sb_err_d = 1'b1;
            end else begin
               cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
         end
      end
   end

   always_comb begin
      stall_a = (src_a != RNONE) && (cnt_q[src_a] != '0);
      stall_b = (src_b != RNONE) && (cnt_q[src_b] != '0);
`ifdef REGFILE_BYPASS_EN
      // The final outstanding write is forwarded by the data bypass.
      if (cnt_q[src_a] == CNT_ONE && dec[src_a]) stall_a = 1'b0;
      if (cnt_q[src_b] == CNT_ONE && dec[src_b]) stall_b = 1'b0;
`endif
      stall = stall_a || stall_b;
   end

   assign sb_err = sb_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
         sb_err_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
         sb_err_q <= sb_err_d;
      end
   end

endmodule

// File: rtl/y86_regfile_sb.sv
// rtl/y86_regfile_sb.sv - Y86 register file with write-back priority, optional bypass and pending scoreboard
//
// Purpose : DATA_W x NREGS register file; last ID (RNONE) reads 0 and ignores writes.
// Ports   : clk, rst_n (async active-low)
//           rf (y86_regfile_sb_if.slave) - srcA/srcB -> valA/valB (combinational),
//           write-backs E/M (M wins on same dst), issue iss_en/iss_dstE/iss_dstM,
//           iss_rdy, stall, sb_err.
// Config  : REGFILE_BYPASS_EN - reads see same-cycle write-back data (M over E).
module y86_regfile_sb
   import y86_regfile_sb_pkg::*;
#(
   parameter int                DATA_W    = 64,
   parameter int                NREGS     = 16,
   parameter int                PEND_W    = 2,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input logic              clk,
   input logic              rst_n,
   y86_regfile_sb_if.slave  rf
);

   localparam int            RW    = $clog2(NREGS);
   localparam logic [RW-1:0] RNONE = RW'(NREGS - 1);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [DATA_W-1:0] val_a;
   logic [DATA_W-1:0] val_b;

   // M applied after E so it wins when both target the same register.
   always_comb begin
      regs_d = regs_q;
      if (rf.wenE && rf.dstE != RNONE) regs_d[rf.dstE] = rf.valE;
      if (rf.wenM && rf.dstM != RNONE) regs_d[rf.dstM] = rf.valM;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) regs_q[r] <= RESET_VAL;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      val_a = (rf.srcA == RNONE) ? '0 : regs_q[rf.srcA];
      val_b = (rf.srcB == RNONE) ? '0 : regs_q[rf.srcB];
`ifdef REGFILE_BYPASS_EN
      if (rf.srcA != RNONE) begin
         if (rf.wenM && rf.dstM == rf.srcA)      val_a = rf.valM;
         else if (rf.wenE && rf.dstE == rf.srcA) val_a = rf.valE;
      end
      if (rf.srcB != RNONE) begin
         if (rf.wenM && rf.dstM == rf.srcB)      val_b = rf.valM;
         else if (rf.wenE && rf.dstE == rf.srcB) val_b = rf.valE;
      end
`endif
   end

   assign rf.valA = val_a;
   assign rf.valB = val_b;

   y86_regfile_sb_scoreboard #(
      .NREGS  (NREGS),
      .PEND_W (PEND_W),
      .RW     (RW)
   ) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_a     (rf.srcA),
      .src_b     (rf.srcB),
      .wen_e     (rf.wenE),
      .dst_e     (rf.dstE),
      .wen_m     (rf.wenM),
      .dst_m     (rf.dstM),
      .iss_en    (rf.iss_en),
      .iss_dst_e (rf.iss_dstE),
      .iss_dst_m (rf.iss_dstM),
      .iss_rdy   (rf.iss_rdy),
      .stall     (rf.stall),
      .sb_err    (rf.sb_err)
   );

endmodule
